vend_controller: RTL and testbench

Sequencing controller for the vending machine datapath: accepts coin pulses, tracks credit, matches item selections against per-item prices, dispenses, and pays change as a timed pulse train. It sits between the coin-slot front end and the dispense and change mechanisms. It owns the credit value and drives the clear of the coin counter display.

---
 rtl/vend_pkg.sv | 17 +
 rtl/vend_if.sv | 32 +++
 rtl/change_dispenser.sv | 55 +++++
 rtl/vend_controller.sv | 175 +++++++++++++++++
 tb/tb_vend_controller.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending machine sequencing controller.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CREDIT,
    VEND,
    CHANGE
  } state_t;

  typedef logic [9:0] credit_t;

  localparam credit_t NICKEL  = 10'd5;
  localparam credit_t DIME    = 10'd10;
  localparam credit_t QUARTER = 10'd25;

endpackage

// File: rtl/vend_if.sv
// Coin-slot / selection inputs and dispense / change outputs of the vending controller.
interface vend_if;

  logic                 inQuarter;
  logic                 inDime;
  logic                 inNickel;
  logic [1:0]           inSelect;
  logic                 inSelectValid;
  logic                 inCancel;
  vend_pkg::credit_t    outCredit;
  logic                 outDispense;
  logic [1:0]           outItem;
  logic                 outInsufficient;
  logic                 outCoinReject;
  logic                 outNickelOut;
  logic                 outQuarterOut;
  logic                 outBusy;
  logic                 outResetCount;

  modport master (
    output inQuarter, inDime, inNickel, inSelect, inSelectValid, inCancel,
    input  outCredit, outDispense, outItem, outInsufficient, outCoinReject,
           outNickelOut, outQuarterOut, outBusy, outResetCount
  );

  modport slave (
    input  inQuarter, inDime, inNickel, inSelect, inSelectValid, inCancel,
    output outCredit, outDispense, outItem, outInsufficient, outCoinReject,
           outNickelOut, outQuarterOut, outBusy, outResetCount
  );

endinterface

// File: rtl/change_dispenser.sv
// Change pulse pacing: one coin every CHANGE_GAP cycles, first on the start strobe.
// VEND_QUARTER_CHANGE_EN enables quarters before nickels; otherwise nickels only.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int CHANGE_GAP = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    start,
  input  credit_t credit,
  output logic    nickel,
  output logic    quarter,
  output logic    done
);

  localparam int GW = $clog2(CHANGE_GAP);

  logic          active;
  logic [GW-1:0] gap_cnt;
  logic          tick;
  logic          fire;

  assign tick = start || (active && gap_cnt == '0);

`ifdef VEND_QUARTER_CHANGE_EN
  assign quarter = tick && (credit >= QUARTER);
  assign nickel  = tick && (credit < QUARTER) && (credit >= NICKEL);
`else
  assign quarter = 1'b0;
  assign nickel  = tick && (credit >= NICKEL);
`endif

  assign fire = nickel || quarter;
  assign done = active && (credit == '0);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active  <= 1'b0;
      gap_cnt <= '0;
    end else begin
      if (start)
        active <= 1'b1;
      else if (done)
        active <= 1'b0;

      if (fire)
        gap_cnt <= GW'(CHANGE_GAP - 1);
      else if (active && gap_cnt != '0)
        gap_cnt <= gap_cnt - GW'(1);
    end
  end

endmodule

// File: rtl/vend_controller.sv
// Vending sequencer: coin credit, price match, dispense, and timed change payout.
// Optional quarter change is selected by VEND_QUARTER_CHANGE_EN (see change_dispenser).
module vend_controller
  import vend_pkg::*;
#(
  parameter int PRICE0     = 75,
  parameter int PRICE1     = 100,
  parameter int PRICE2     = 125,
  parameter int PRICE3     = 150,
  parameter int MAX_CREDIT = 1000,
  parameter int CHANGE_GAP = 4
) (
  input  logic clk,
  input  logic reset,
  vend_if.slave bus
);

  if ((PRICE0 % 5) != 0 || (PRICE1 % 5) != 0 || (PRICE2 % 5) != 0 ||
      (PRICE3 % 5) != 0 || (MAX_CREDIT % 5) != 0) begin : g_bad_multiple
    $error("vend_controller: prices and MAX_CREDIT must be multiples of 5");
  end
  if (MAX_CREDIT > 1023 || PRICE0 > 1023 || PRICE1 > 1023 ||
      PRICE2 > 1023 || PRICE3 > 1023) begin : g_bad_range
    $error("vend_controller: prices and MAX_CREDIT must fit in 10 bits");
  end
  if (CHANGE_GAP < 2) begin : g_bad_gap
    $error("vend_controller: CHANGE_GAP must be at least 2");
  end

  state_t      state, state_n;
  credit_t     credit_q, credit_n;
  logic        dispense_q, dispense_n;
  logic [1:0]  item_q, item_n;
  logic        insuff_q, insuff_n;
  logic        reject_q, reject_n;
  logic        nickel_q, quarter_q;
  logic        busy_q, busy_n;
  logic        rst_cnt_q, rst_cnt_n;

  credit_t     coin_sum;
  logic [10:0] coin_total;
  logic        coin_any;
  logic        coin_fits;
  logic        take_coins;
  credit_t     price;
  logic        start;
  logic        nickel_fire, quarter_fire, change_done;

  assign coin_sum   = (bus.inQuarter ? QUARTER : '0) +
                      (bus.inDime    ? DIME    : '0) +
                      (bus.inNickel  ? NICKEL  : '0);
  assign coin_any   = bus.inQuarter || bus.inDime || bus.inNickel;
  assign coin_total = {1'b0, credit_q} + {1'b0, coin_sum};
  assign coin_fits  = coin_total <= 11'(MAX_CREDIT);

  always_comb begin
    case (bus.inSelect)
      2'd0:    price = credit_t'(PRICE0);
      2'd1:    price = credit_t'(PRICE1);
      2'd2:    price = credit_t'(PRICE2);
      default: price = credit_t'(PRICE3);
    endcase
  end

  // Payout starts on a refund, or after a vend that leaves credit behind.
  assign start = (state == CREDIT && bus.inCancel) ||
                 (state == VEND && credit_q != '0);

  change_dispenser #(
    .CHANGE_GAP(CHANGE_GAP)
  ) u_change (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .credit (credit_q),
    .nickel (nickel_fire),
    .quarter(quarter_fire),
    .done   (change_done)
  );

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    state_n    = state;
    credit_n   = credit_q;
    dispense_n = 1'b0;
    item_n     = 2'd0;
    insuff_n   = 1'b0;
    reject_n   = 1'b0;
    rst_cnt_n  = 1'b0;
    take_coins = 1'b0;

    case (state)
      IDLE: begin
        insuff_n   = bus.inSelectValid;
        take_coins = 1'b1;
      end
      CREDIT: begin
        if (bus.inCancel) begin
          state_n = CHANGE;
        end else if (bus.inSelectValid && credit_q >= price) begin
          state_n    = VEND;
          dispense_n = 1'b1;
          item_n     = bus.inSelect;
          credit_n   = credit_q - price;
        end else begin
          insuff_n   = bus.inSelectValid;
          take_coins = 1'b1;
        end
      end
      VEND: begin
        state_n = (credit_q != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        if (change_done) begin
          state_n   = IDLE;
          rst_cnt_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (coin_any) begin
      if (take_coins && coin_fits) begin
        credit_n = coin_total[9:0];
        state_n  = CREDIT;
      end else begin
        reject_n = 1'b1;
      end
    end

    if (nickel_fire)
      credit_n = credit_n - NICKEL;
    if (quarter_fire)
      credit_n = credit_n - QUARTER;

    busy_n = (state_n == VEND) || (state_n == CHANGE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      credit_q   <= '0;
      dispense_q <= 1'b0;
      item_q     <= 2'd0;
      insuff_q   <= 1'b0;
      reject_q   <= 1'b0;
      nickel_q   <= 1'b0;
      quarter_q  <= 1'b0;
      busy_q     <= 1'b0;
      rst_cnt_q  <= 1'b0;
    end else begin
      state      <= state_n;
      credit_q   <= credit_n;
      dispense_q <= dispense_n;
      item_q     <= item_n;
      insuff_q   <= insuff_n;
      reject_q   <= reject_n;
      nickel_q   <= nickel_fire;
      quarter_q  <= quarter_fire;
      busy_q     <= busy_n;
      rst_cnt_q  <= rst_cnt_n;
    end
  end

  assign bus.outCredit       = credit_q;
  assign bus.outDispense     = dispense_q;
  assign bus.outItem         = item_q;
  assign bus.outInsufficient = insuff_q;
  assign bus.outCoinReject   = reject_q;
  assign bus.outNickelOut    = nickel_q;
  assign bus.outQuarterOut   = quarter_q;
  assign bus.outBusy         = busy_q;
  assign bus.outResetCount   = rst_cnt_q;

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller with default parameters.
module tb_vend_controller;

  localparam int GAP = 4;

`ifdef VEND_QUARTER_CHANGE_EN
  localparam int REF40_N = 3;
  localparam int REF40_Q = 1;
  localparam int REF40_LAST = 12;
`else
  localparam int REF40_N = 8;
  localparam int REF40_Q = 0;
  localparam int REF40_LAST = 28;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  vend_if bus ();

  vend_controller dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_cnt, q_cnt, first_idx, last_idx, rc_idx;
  int gap_bad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply inputs for one rising edge, then return at the following falling edge.
  task automatic tick(input bit q, input bit d, input bit n, input bit sv,
                      input logic [1:0] sel, input bit c);
    bus.inQuarter     = q;
    bus.inDime        = d;
    bus.inNickel      = n;
    bus.inSelectValid = sv;
    bus.inSelect      = sel;
    bus.inCancel      = c;
    @(negedge clk);
    bus.inQuarter     = 1'b0;
    bus.inDime        = 1'b0;
    bus.inNickel      = 1'b0;
    bus.inSelectValid = 1'b0;
    bus.inSelect      = 2'd0;
    bus.inCancel      = 1'b0;
  endtask

  // Observe change pulses starting at the current falling edge (index 0).
  task automatic watch(input int limit, input int stop_after);
    n_cnt = 0; q_cnt = 0; first_idx = -1; last_idx = -1; rc_idx = -1; gap_bad = 0;
    for (int i = 0; i < limit; i++) begin
      if (i > 0) @(negedge clk);
      if (bus.outNickelOut || bus.outQuarterOut) begin
        if (bus.outNickelOut)  n_cnt++;
        if (bus.outQuarterOut) q_cnt++;
        if (first_idx < 0) first_idx = i;
        if (((i - first_idx) % GAP) != 0) gap_bad = 1;
        last_idx = i;
      end
      if (bus.outResetCount) begin
        rc_idx = i;
        break;
      end
      if (stop_after != 0 && (n_cnt + q_cnt) == stop_after) break;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.inQuarter = 1'b0; bus.inDime = 1'b0; bus.inNickel = 1'b0;
    bus.inSelect = 2'd0; bus.inSelectValid = 1'b0; bus.inCancel = 1'b0;
    #1 reset = 1'b1;
    @(negedge clk);
    check("reset_credit", bus.outCredit, 0);
    check("reset_pulses", {bus.outDispense, bus.outItem, bus.outInsufficient, bus.outCoinReject,
                           bus.outNickelOut, bus.outQuarterOut, bus.outBusy, bus.outResetCount}, 0);
    reset = 1'b0;
    @(negedge clk);

    // Single coins accumulate with one-cycle latency.
    tick(1, 0, 0, 0, 2'd0, 0);
    check("credit_q", bus.outCredit, 25);
    tick(0, 1, 0, 0, 2'd0, 0);
    check("credit_qd", bus.outCredit, 35);
    tick(0, 0, 1, 0, 2'd0, 0);
    check("credit_qdn", bus.outCredit, 40);
    check("coin_no_pulses", {bus.outDispense, bus.outInsufficient, bus.outCoinReject, bus.outBusy}, 0);

    // Refund of 40 with a coin arriving alongside the cancel.
    tick(0, 0, 1, 0, 2'd0, 1);
    check("cancel_coin_reject", bus.outCoinReject, 1);
    check("refund_busy", bus.outBusy, 1);
    watch(40, 0);
    check("refund_nickels", n_cnt, REF40_N);
    check("refund_quarters", q_cnt, REF40_Q);
    check("refund_first", first_idx, 0);
    check("refund_last", last_idx, REF40_LAST);
    check("refund_spacing", gap_bad, 0);
    check("refund_rc_idx", rc_idx, REF40_LAST + 1);
    check("refund_credit0", bus.outCredit, 0);
    @(negedge clk);
    check("refund_rc_one_cycle", bus.outResetCount, 0);
    check("refund_idle", bus.outBusy, 0);

    // Exact-price vend; a nickel with the accepted selection is returned.
    for (int i = 0; i < 4; i++) tick(1, 0, 0, 0, 2'd0, 0);
    check("credit_100", bus.outCredit, 100);
    tick(0, 0, 1, 1, 2'd1, 0);
    check("vend1_dispense", bus.outDispense, 1);
    check("vend1_item", bus.outItem, 1);
    check("vend1_credit", bus.outCredit, 0);
    check("vend1_coin_reject", bus.outCoinReject, 1);
    check("vend1_busy", bus.outBusy, 1);
    @(negedge clk);
    watch(8, 0);
    check("vend1_no_change", n_cnt + q_cnt, 0);
    check("vend1_idle", {bus.outBusy, bus.outDispense}, 0);

    // Selection with no credit is refused.
    tick(0, 0, 0, 1, 2'd2, 0);
    check("idle_select_insuff", bus.outInsufficient, 1);
    check("idle_select_credit", bus.outCredit, 0);

    // Insufficient credit keeps the machine in CREDIT.
    for (int i = 0; i < 3; i++) tick(1, 0, 0, 0, 2'd0, 0);
    check("credit_75", bus.outCredit, 75);
    tick(0, 0, 0, 1, 2'd3, 0);
    check("insuff_pulse", bus.outInsufficient, 1);
    check("insuff_credit", bus.outCredit, 75);
    check("insuff_no_dispense", {bus.outDispense, bus.outBusy}, 0);
    tick(0, 0, 0, 0, 2'd0, 0);
    check("insuff_one_cycle", bus.outInsufficient, 0);
    tick(0, 0, 0, 1, 2'd0, 0);
    check("vend0_dispense", {bus.outDispense, bus.outItem}, 3'b100);
    check("vend0_credit", bus.outCredit, 0);
    tick(0, 1, 0, 0, 2'd0, 0);
    check("vend_coin_reject", bus.outCoinReject, 1);
    check("vend_coin_credit", bus.outCredit, 0);

    // Vend leaving 10 cents pays two nickels.
    for (int i = 0; i < 4; i++) tick(1, 0, 0, 0, 2'd0, 0);
    tick(0, 1, 0, 0, 2'd0, 0);
    check("credit_110", bus.outCredit, 110);
    tick(0, 0, 0, 1, 2'd1, 0);
    check("vend_change_credit", bus.outCredit, 10);
    @(negedge clk);
    watch(12, 0);
    check("vend_change_nickels", n_cnt, 2);
    check("vend_change_quarters", q_cnt, 0);
    check("vend_change_last", last_idx, 4);
    check("vend_change_rc", rc_idx, 5);

    // Credit ceiling.
    for (int i = 0; i < 39; i++) tick(1, 0, 0, 0, 2'd0, 0);
    tick(0, 1, 1, 0, 2'd0, 0);
    check("credit_990", bus.outCredit, 990);
    tick(1, 1, 0, 0, 2'd0, 0);
    check("over_reject", bus.outCoinReject, 1);
    check("over_credit", bus.outCredit, 990);
    tick(0, 0, 1, 0, 2'd0, 0);
    check("credit_995", {bus.outCoinReject, bus.outCredit}, 995);
    tick(0, 0, 1, 0, 2'd0, 0);
    check("credit_1000_exact", {bus.outCoinReject, bus.outCredit}, 1000);
    tick(0, 0, 1, 0, 2'd0, 0);
    check("credit_1005_reject", {bus.outCoinReject, bus.outCredit}, 11'h400 | 11'd1000);

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset_clears_credit", bus.outCredit, 0);

    // Simultaneous coins sum; reset interrupts a refund.
    tick(1, 1, 1, 0, 2'd0, 0);
    check("credit_sum_40", bus.outCredit, 40);
    tick(0, 0, 0, 0, 2'd0, 1);
    watch(20, 2);
    check("pre_reset_pulses", n_cnt + q_cnt, 2);
    #2 reset = 1'b1;
    #1;
    check("async_reset_credit", bus.outCredit, 0);
    check("async_reset_outs", {bus.outDispense, bus.outItem, bus.outInsufficient, bus.outCoinReject,
                               bus.outNickelOut, bus.outQuarterOut, bus.outBusy, bus.outResetCount}, 0);
    @(negedge clk);
    reset = 1'b0;
    watch(12, 0);
    check("post_reset_no_pulses", n_cnt + q_cnt, 0);
    check("post_reset_idle", {bus.outBusy, bus.outResetCount, bus.outCredit}, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
